// File: rtl/conv_pkg.sv
// Shared definitions for the 1x1 convolution datapath: operand format,
// saturation bounds and the channel-accumulator state encoding.
package conv_pkg;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 16;

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_t;

endpackage : conv_pkg

// File: rtl/acc_saturate.sv
// Combinational clamp of a wide signed accumulator to a DATA_W signed result,
// flagging when either bound was applied.
module acc_saturate #(
  parameter int ACC_W  = 35,
  parameter int DATA_W = 32
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [DATA_W-1:0] sat_out,
  output logic                     overflow
);

  // The value fits iff every bit from the DATA_W sign bit upward matches.
  logic [ACC_W-DATA_W:0] upper;

  assign upper    = acc[ACC_W-1:DATA_W-1];
  assign overflow = !((&upper) || !(|upper));

  always_comb begin
    if (!overflow)
      sat_out = acc[DATA_W-1:0];
    else if (acc[ACC_W-1])
      sat_out = {1'b1, {(DATA_W-1){1'b0}}};
    else
      sat_out = {1'b0, {(DATA_W-1){1'b1}}};
  end

endmodule : acc_saturate

// File: rtl/conv1x1_channel_accumulator.sv
// Sums NUM_CH per-channel Q16.16 products plus a per-pixel bias and emits one
// saturated result per pixel. Optional ReLU via `define CONV1X1_ACC_RELU_EN.
module conv1x1_channel_accumulator #(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int FRAC_W = conv_pkg::FRAC_W,
  parameter int NUM_CH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Data_In,
  input  logic              Valid_In,
  input  logic [DATA_W-1:0] Bias,
  input  logic              Clear,
  output logic [DATA_W-1:0] Data_Out,
  output logic              Valid_Out,
  output logic              Sat_Flag
);
  import conv_pkg::*;

  localparam int ACC_W = DATA_W + $clog2(NUM_CH + 1);
  localparam int CNT_W = $clog2(NUM_CH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CH - 1);

  if (NUM_CH < 1 || FRAC_W >= DATA_W) begin : g_bad_cfg
    $error("conv1x1_channel_accumulator: invalid NUM_CH/FRAC_W");
  end

  acc_state_t              state, state_next;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] beat_sum;
  logic [DATA_W-1:0]       sat_out;
  logic [DATA_W-1:0]       result;
  logic                    sat_ovf;
  logic                    beat;
  logic                    last_beat;

  // Clear wins over Valid_In: a colliding beat is simply dropped.
  assign beat      = Valid_In && !Clear;
  assign last_beat = beat && (cnt == LAST_CNT);

  // The first beat of a pixel seeds the sum with the bias instead of acc.
  assign beat_sum = ((state == IDLE) ? ACC_W'($signed(Bias)) : acc)
                  + ACC_W'($signed(Data_In));

  acc_saturate #(
    .ACC_W (ACC_W),
    .DATA_W(DATA_W)
  ) u_sat (
    .acc     (beat_sum),
    .sat_out (sat_out),
    .overflow(sat_ovf)
  );

`ifdef CONV1X1_ACC_RELU_EN
  assign result = sat_out[DATA_W-1] ? '0 : sat_out;
`else
  assign result = sat_out;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    if (Clear)
      state_next = IDLE;
    else if (Valid_In)
      state_next = last_beat ? IDLE : ACCUM;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      Data_Out  <= '0;
      Valid_Out <= 1'b0;
      Sat_Flag  <= 1'b0;
    end else begin
      Valid_Out <= last_beat;
      if (Clear) begin
        cnt <= '0;
        acc <= '0;
      end else if (Valid_In) begin
        cnt <= last_beat ? '0 : cnt + 1'b1;
        acc <= beat_sum;
      end
      if (last_beat) begin
        Data_Out <= result;
        if (sat_ovf) Sat_Flag <= 1'b1;
      end
    end
  end

endmodule : conv1x1_channel_accumulator

// File: tb/tb_conv1x1_channel_accumulator.sv
// Directed, table-driven bench for conv1x1_channel_accumulator with NUM_CH=4;
// honours CONV1X1_ACC_RELU_EN in its expected values.
module tb_conv1x1_channel_accumulator;
  import conv_pkg::*;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Data_In;
  logic        Valid_In;
  logic [31:0] Bias;
  logic        Clear;
  logic [31:0] Data_Out;
  logic        Valid_Out;
  logic        Sat_Flag;

  int total = 0;
  int bad   = 0;
  logic sat_model = 1'b0;

  conv1x1_channel_accumulator #(
    .DATA_W(32),
    .FRAC_W(16),
    .NUM_CH(NCH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Data_In  (Data_In),
    .Valid_In (Valid_In),
    .Bias     (Bias),
    .Clear    (Clear),
    .Data_Out (Data_Out),
    .Valid_Out(Valid_Out),
    .Sat_Flag (Sat_Flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      bias;
    logic [3:0][31:0] p;      // p[0] is the first beat
    int               gap;    // idle cycles between beats of this pixel
    logic [31:0]      exp;    // saturated sum before ReLU
    logic             sat;    // this pixel clamps
  } vec_t;

  vec_t vecs[11];

  function automatic logic [31:0] post_relu(input logic [31:0] x);
`ifdef CONV1X1_ACC_RELU_EN
    return x[31] ? 32'h0 : x;
`else
    return x;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Drive one cycle, then check what the edge produced.
  task automatic step(input logic v, input logic [31:0] d, input logic [31:0] b,
                      input logic clr, input logic exp_v, input logic [31:0] exp_d);
    Valid_In = v;
    Data_In  = d;
    Bias     = b;
    Clear    = clr;
    @(posedge clk);
    #1;
    check("valid_out", {31'b0, Valid_Out}, {31'b0, exp_v});
    if (exp_v) check("data_out", Data_Out, exp_d);
  endtask

  task automatic run_pixel(input vec_t v);
    for (int k = 0; k < NCH; k++) begin
      // Bias wobbles after the first beat; only the first-beat value counts.
      step(1'b1, v.p[k], (k == 0) ? v.bias : 32'h1234_5678, 1'b0,
           (k == NCH - 1), post_relu(v.exp));
      if (k < NCH - 1)
        for (int g = 0; g < v.gap; g++) step(1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 32'h0);
    end
    sat_model = sat_model | v.sat;
    check("sat_flag", {31'b0, Sat_Flag}, {31'b0, sat_model});
  endtask

  initial begin
    vecs[0]  = '{32'h0000_8000, {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000}, 0, 32'h000A_8000, 1'b0};
    vecs[1]  = '{32'h0000_8000, {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000}, 1, 32'h000A_8000, 1'b0};
    vecs[2]  = '{32'h0000_8000, {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000}, 3, 32'h000A_8000, 1'b0};
    vecs[3]  = '{32'h0000_8000, {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000}, 0, 32'h000A_8000, 1'b0};
    vecs[4]  = '{32'h0000_8000, {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000}, 0, 32'h000A_8000, 1'b0};
    // Exact bounds are reached without clamping.
    vecs[5]  = '{32'h7FFF_FFFF, {32'h0, 32'h0, 32'h0, 32'h0}, 0, SAT_MAX, 1'b0};
    vecs[6]  = '{32'h8000_0000, {32'h0, 32'h0, 32'h0, 32'h0}, 0, SAT_MIN, 1'b0};
    // -1.0 + -1.0 + 0.5 + 0.5 = -1.0
    vecs[7]  = '{32'h0, {32'h0000_8000, 32'h0000_8000, 32'hFFFF_0000, 32'hFFFF_0000}, 2, 32'hFFFF_0000, 1'b0};
    // One LSB past the top bound.
    vecs[8]  = '{32'h7FFF_FFFF, {32'h1, 32'h0, 32'h0, 32'h0}, 0, SAT_MAX, 1'b1};
    vecs[9]  = '{32'h0, {32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000}, 0, SAT_MAX, 1'b1};
    vecs[10] = '{32'h8000_0000, {32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000}, 1, SAT_MIN, 1'b1};

    rst = 1'b1;
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("reset data_out", Data_Out, 32'h0);
    check("reset sat_flag", {31'b0, Sat_Flag}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_pixel(vecs[i]);

    // Sticky flag survives an unsaturated pixel.
    run_pixel(vecs[0]);

    // Clear collides with the 3rd beat; the next 4 beats are a fresh pixel.
    step(1'b1, 32'h0001_0000, 32'h0000_8000, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0002_0000, 32'h0000_8000, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0003_0000, 32'h0000_8000, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0002_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0003_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0004_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 32'h000B_0000);
    // Clear on its own one cycle later leaves the held result alone.
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("hold after clear", Data_Out, 32'h000B_0000);

    // Reset after two beats wipes everything, including the sticky flag.
    step(1'b1, 32'h0001_0000, 32'h0000_8000, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0002_0000, 32'h0000_8000, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    step(1'b1, 32'h0003_0000, 32'h0000_8000, 1'b0, 1'b0, 32'h0);
    check("rst data_out", Data_Out, 32'h0);
    check("rst sat_flag", {31'b0, Sat_Flag}, 32'h0);
    rst = 1'b0;
    sat_model = 1'b0;
    run_pixel(vecs[0]);

    // Reset landing on a last beat suppresses its pulse.
    step(1'b1, 32'h0001_0000, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0001_0000, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0001_0000, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    step(1'b1, 32'h0001_0000, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    run_pixel(vecs[7]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_conv1x1_channel_accumulator

// File: doc/conv1x1_channel_accumulator.md
# conv1x1_channel_accumulator

Stage directly downstream of the 1x1/stride-1 convolution. It takes the per-input-channel product stream (one 32-bit Q16.16 product per `Valid_In` beat) and sums `NUM_CH` consecutive products plus a per-output-channel bias. It emits one saturated 32-bit result per output pixel. This result feeds the activation/write-back path of the layer.

## Interface
- `DATA_W`, default 32: width of products, bias and result (signed Q16.16).
- `FRAC_W`, default 16: fractional bits. Informational only, since all operands share the same format and no rescale is done.
- `NUM_CH`, default 16: input channels summed per output pixel. Must be at least 1.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `Data_In`  in  32: signed product from the convolution stage.
- `Valid_In`  in  1: `Data_In` is valid this cycle. No backpressure.
- `Bias`  in  32: signed bias. Sampled only on the first beat of each pixel.
- `Clear`  in  1: synchronous abort of the current partial sum.
- `Data_Out`  out  32: saturated signed sum.
- `Valid_Out`  out  1: one-cycle pulse qualifying `Data_Out`.
- `Sat_Flag`  out  1: sticky flag, set when any result saturated. Cleared only by `rst`.

## Operation
- Internal accumulator width is `ACC_W = DATA_W + clog2(NUM_CH+1)`, declared as a localparam. It never overflows internally.
- State machine:
  - `IDLE`: channel count is 0.
    - `Valid_In` loads `acc = sext(Bias) + sext(Data_In)` and sets count = 1.
    - Goes to `ACCUM`, or straight to output when `NUM_CH == 1`.
  - `ACCUM`: each `Valid_In` does `acc += sext(Data_In)` and count++.
    - On the beat where count reaches `NUM_CH`, the final sum goes to the output stage. Count returns to 0 and state to `IDLE`.
  - Cycles without `Valid_In` hold all state. Gaps of any length are allowed between beats.
- Output stage:
  - If the sum is above `0x7FFFFFFF`, output `0x7FFFFFFF`.
  - If the sum is below `0x80000000`, output `0x80000000`.
  - Either clamp sets `Sat_Flag`. Otherwise output the low 32 bits.
  - Then apply optional ReLU (see Configuration), register the result, and pulse `Valid_Out`.
- `Clear` has priority over `Valid_In` in the same cycle:
  - the beat is dropped;
  - count goes to 0 and state to `IDLE`;
  - no `Valid_Out` is produced for the aborted pixel.
- `Clear` does not cancel a `Valid_Out` already registered for a completed pixel.
- `Data_Out` holds its last value between pulses.

## Timing
- Reset values: `Data_Out = 0`, `Valid_Out = 0`, `Sat_Flag = 0`, count = 0, state `IDLE`, accumulator = 0.
- Latency: `Valid_Out` is high exactly 1 cycle after the clock edge that samples the `NUM_CH`-th `Valid_In` beat.
- Back-to-back pixels: the first beat of pixel n+1 may arrive in the cycle right after the last beat of pixel n. Throughput is 1 beat per cycle, with no bubbles.
- `rst` asserted mid-pixel discards the partial sum. Any pending `Valid_Out` is suppressed in the following cycle.
- `Bias` may change on any cycle. Only the value present on a pixel's first accepted beat is used.

## Configuration
- `CONV1X1_ACC_RELU_EN` defined: after saturation, negative results are forced to `0x00000000`. Zero and positive results pass unchanged. `Sat_Flag` still reflects negative clamping that happened before ReLU.
- Macro undefined: the signed saturated sum is output directly.

## Structure
- Shared package `conv_pkg`:
  - `DATA_W`, `FRAC_W`;
  - `SAT_MAX = 32'h7FFFFFFF`, `SAT_MIN = 32'h80000000`;
  - the `acc_state_t` enum (`IDLE`, `ACCUM`).
- One sub-module, `acc_saturate`: combinational clamp from `ACC_W` down to `DATA_W`, with an overflow indication.
- Counter, state machine, accumulator, ReLU and output register stay in the top module.

## Test plan
- Basic sum: `NUM_CH = 4`, `Bias = 0x00008000` (0.5), products 1.0, 2.0, 3.0, 4.0 (`0x00010000` through `0x00040000`) on consecutive cycles -> `Data_Out = 0x000A8000`, one `Valid_Out` pulse 1 cycle after the 4th beat, `Sat_Flag = 0`.
- Gaps and back-to-back:
  - Stimulus: same four products with 0 to 3 idle cycles between beats, then 8 more beats with no gaps.
  - Response: exactly 3 pulses, each equal to the reference sum, and each 1 cycle after its pixel's last beat.
- Positive saturation: `Bias = 0`, four `0x7FFF0000` beats -> `Data_Out = 0x7FFFFFFF`, `Sat_Flag` rises and stays 1 through later unsaturated pixels.
- Negative sum and ReLU:
  - Stimulus: `Bias = 0`, products −1.0, −1.0, 0.5, 0.5, giving a sum of −1.0.
  - Response: `Data_Out = 0xFFFF0000` without `CONV1X1_ACC_RELU_EN`, and `0x00000000` with it.
- `Clear` collision: `Clear` together with `Valid_In` on the 3rd beat -> no `Valid_Out`, and the next 4 beats form a fresh pixel with the correct sum using the bias sampled on its own first beat.
- Reset mid-pixel: assert `rst` after 2 beats -> all outputs read 0 the next cycle, and the following 4-beat pixel produces the correct sum.
